// File: rtl/univ_shift_reg.sv
// Parametrised universal register: parallel load, logical/arithmetic shifts,
// rotates and a registered carry-out of the last bit shifted or rotated out.
module univ_shift_reg #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si_lsb,
    input  logic             si_msb,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             co
);

    typedef enum logic [2:0] {
        OpHold = 3'b000,
        OpLoad = 3'b001,
        OpShl  = 3'b010,
        OpShr  = 3'b011,
        OpRotl = 3'b100,
        OpRotr = 3'b101,
        OpAsr  = 3'b110,
        OpClr  = 3'b111
    } op_e;

    logic [WIDTH-1:0] q_d, q_q;
    logic             co_d, co_q;

    always_comb begin
        q_d  = q_q;
        co_d = co_q;
        if (en) begin
            unique case (op_e'(op))
                OpHold: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
                OpLoad: begin
                    q_d  = d;
                    co_d = 1'b0;
                end
                OpShl: begin
                    q_d  = {q_q[WIDTH-2:0], si_lsb};
                    co_d = q_q[WIDTH-1];
                end
                OpShr: begin
                    q_d  = {si_msb, q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                OpRotl: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    co_d = q_q[WIDTH-1];
                end
                OpRotr: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                OpAsr: begin
                    q_d  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                OpClr: begin
                    q_d  = '0;
                    co_d = 1'b0;
                end
                default: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
            endcase
        end
    end

    // Reset wins over enable and op decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= RESET_VALUE;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            co_q <= co_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign co    = co_q;

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised N-bit universal register, the multi-bit successor to the single-bit D flip-flop. It adds a synchronous reset, a clock enable, parallel load, logical/arithmetic shifts, rotates, and a registered carry-out of the last bit shifted out. Intended as the general storage/shift element for datapath exercises (serial converters, multiply/divide shift stages, rotating pattern generators). Complementary output `q_bar` is retained from the flip-flop.

## Interface
- `WIDTH`, default 8: register width in bits; WIDTH ≥ 2.
- `RESET_VALUE`, default {WIDTH{1'b0}}: value loaded into `q` on reset.

- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: clock enable; 0 = hold all state.
- `op`  in  3: operation select, sampled at the rising edge.
- `d`  in  WIDTH: parallel load data.
- `si_lsb`  in  1: serial input shifted into bit 0 on shift-left.
- `si_msb`  in  1: serial input shifted into bit WIDTH-1 on logical shift-right.
- `q`  out  WIDTH: register contents.
- `q_bar`  out  WIDTH: bitwise complement of `q`, always ~q.
- `co`  out  1: registered carry-out, the bit shifted or rotated out by the last shift/rotate op.

## Operation
- Priority at each rising edge: `reset` > `en` = 0 (hold) > `op` decode.
- `reset` = 1: q ← RESET_VALUE, co ← 0, regardless of `en`/`op`.
- `en` = 0: q and co keep their values.
- `op` encoding (en = 1), where Q is q before the edge:
  - 000 HOLD: q ← Q; co unchanged.
  - 001 LOAD: q ← d; co ← 0.
  - 010 SHL: q ← {Q[W-2:0], si_lsb}; co ← Q[W-1].
  - 011 SHR (logical): q ← {si_msb, Q[W-1:1]}; co ← Q[0].
  - 100 ROTL: q ← {Q[W-2:0], Q[W-1]}; co ← Q[W-1].
  - 101 ROTR: q ← {Q[0], Q[W-1:1]}; co ← Q[0].
  - 110 ASR: q ← {Q[W-1], Q[W-1:1]} (sign replicated); co ← Q[0].
  - 111 CLR: q ← 0; co ← 0.
- `si_lsb`/`si_msb` are ignored except in SHL/SHR respectively.
- No internal state beyond q and co; no FSM. Each op is single-cycle and back-to-back ops are allowed every cycle.
- `q_bar` is combinational from the q register, never independently stored, so q ^ q_bar = all-ones at all times after reset.
- Outputs before the first reset edge are X; the bench applies reset before checking.

## Timing
- Latency 1 cycle: inputs sampled at edge N, new q/co visible after edge N, stable for edge N+1.
- `q`, `co` are registered outputs. `q_bar` lags q only by combinational delay (zero cycles).
- Reset takes effect at the first rising edge with reset = 1. Deasserting reset lets the op at the next edge execute normally.
- Reset asserted mid-sequence (e.g. during a rotate chain) aborts it: the next edge yields RESET_VALUE and co = 0, with no partial shift.
- Reset values: q = RESET_VALUE, q_bar = ~RESET_VALUE, co = 0.

## Test plan
- Reset: q holds 8'h5A, assert reset with en = 0, op = 001, d = 8'hFF for one edge → q = 8'h00, q_bar = 8'hFF, co = 0. Repeat with RESET_VALUE = 8'h3C → q = 8'h3C, q_bar = 8'hC3.
- Load/shift: LOAD d = 8'hA5 → q = 8'hA5, co = 0. SHL, si_lsb = 1 → q = 8'h4B, co = 1. SHR, si_msb = 0 → q = 8'h25, co = 1.
- Rotate: load 8'h81, ROTL → q = 8'h03, co = 1. Seven further ROTL (8 total) → q = 8'h81. Load 8'h01, ROTR → q = 8'h80, co = 1.
- Arithmetic shift: load 8'h90, ASR → q = 8'hC8, co = 0. ASR again → q = 8'hE4, co = 0. Load 8'h41, ASR → q = 8'h20, co = 1.
- Enable/clear: q = 8'h3C, co = 1, en = 0, op = LOAD, d = 8'hFF for 3 edges → q = 8'h3C, co = 1 throughout. en = 1, op = CLR → q = 8'h00, co = 0.
- Reset collision: q = 8'hF0, reset = 1 with en = 1, op = SHL on the same edge → q = RESET_VALUE, co = 0. Next edge with reset = 0, op = LOAD d = 8'h12 → q = 8'h12.
